// File: rtl/count_sequence_checker.sv
// count_sequence_checker: locks onto a +1 counter stream, then flags, counts and captures sequence errors.
// Define COUNT_CHECK_STICKY_ERR_EN to make error sticky until clear/reset instead of a per-mismatch pulse.
module count_sequence_checker #(
  parameter int WIDTH     = 8,
  parameter int LOCK_LEN  = 4,
  parameter int LOSS_LEN  = 2,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 count_valid,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     exp_count,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_expected,
  output logic [WIDTH-1:0]     first_err_got
);
  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;
  state_t               state_q, state_d;
  logic [WIDTH-1:0]     exp_q, exp_d, fexp_q, fexp_d, fgot_q, fgot_d;
  logic [3:0]           run_q, run_d, miss_q, miss_d;
  logic                 error_q, error_d, fev_q, fev_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d, err_base;
  logic                 match, err_hit, fev_base, lock_hit, loss_hit;
  assign match    = count_in == exp_q;
  assign err_hit  = count_valid && state_q == LOCKED && !match;
  assign lock_hit = run_q + 4'd1 == 4'(LOCK_LEN);
  assign loss_hit = miss_q + 4'd1 == 4'(LOSS_LEN);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEARCH;
      exp_q       <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      fev_q       <= 1'b0;
      fexp_q      <= '0;
      fgot_q      <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
      fev_q       <= fev_d;
      fexp_q      <= fexp_d;
      fgot_q      <= fgot_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (count_valid)
      state_d = state_q == SEARCH                         ? ACQUIRE :
                state_q == ACQUIRE && match && lock_hit   ? LOCKED  :
                state_q == LOCKED && !match && loss_hit   ? ACQUIRE : state_q;
  end
  // A locked mismatch keeps the expectation free-running so one glitch does not desync.
  always_comb begin
    exp_d  = exp_q;
    run_d  = run_q;
    miss_d = miss_q;
    if (count_valid) begin
      if (state_q == SEARCH) begin
        exp_d = count_in + WIDTH'(1);
        run_d = '0;
      end else if (state_q == ACQUIRE) begin
        exp_d  = match ? exp_q + WIDTH'(1) : count_in + WIDTH'(1);
        run_d  = match ? run_q + 4'd1 : 4'd0;
        miss_d = match && lock_hit ? 4'd0 : miss_q;
      end else if (state_q == LOCKED) begin
        exp_d  = !match && loss_hit ? count_in + WIDTH'(1) : exp_q + WIDTH'(1);
        run_d  = !match && loss_hit ? 4'd0 : run_q;
        miss_d = match ? 4'd0 : miss_q + 4'd1;
      end
    end
  end
  // Clear is applied first so a same-cycle mismatch lands on freshly cleared statistics.
  always_comb begin
    err_base    = clear ? '0 : err_count_q;
    err_count_d = err_hit && err_base != '1 ? err_base + ERR_CNT_W'(1) : err_base;
    fev_base    = !clear && fev_q;
    fev_d       = fev_base || err_hit;
    fexp_d      = clear ? '0 : fexp_q;
    fgot_d      = clear ? '0 : fgot_q;
    if (err_hit && !fev_base) begin
      fexp_d = exp_q;
      fgot_d = count_in;
    end
`ifdef COUNT_CHECK_STICKY_ERR_EN
    error_d = err_hit || (!clear && error_q);
`else
    error_d = err_hit;
`endif
  end
  always_comb begin
    locked             = state_q == LOCKED;
    error              = error_q;
    err_count          = err_count_q;
    exp_count          = exp_q;
    first_err_valid    = fev_q;
    first_err_expected = fexp_q;
    first_err_got      = fgot_q;
  end
endmodule

// File: tb/tb_count_sequence_checker.sv
// tb_count_sequence_checker: table-driven and directed checks of lock, error, clear, wrap and saturation behaviour.
module tb_count_sequence_checker;
  logic        clk = 1'b0;
  logic        reset, count_valid, clear;
  logic [7:0]  count_in;
  logic        locked, error, fev;
  logic [15:0] err_count;
  logic [7:0]  exp_count, fexp, fgot;
  logic        l4, e4, fv4;
  logic [3:0]  ec4;
  logic [7:0]  x4, fe4, fg4;
  int          n_cmp = 0, n_bad = 0;

  count_sequence_checker dut (
    .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid), .clear(clear),
    .locked(locked), .error(error), .err_count(err_count), .exp_count(exp_count),
    .first_err_valid(fev), .first_err_expected(fexp), .first_err_got(fgot));

  count_sequence_checker #(.ERR_CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid), .clear(clear),
    .locked(l4), .error(e4), .err_count(ec4), .exp_count(x4),
    .first_err_valid(fv4), .first_err_expected(fe4), .first_err_got(fg4));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       v, c;
    logic [7:0] cnt;
    logic       lk, ep, es;
    logic [15:0] ec;
    logic [7:0] ex;
    logic       fv;
    logic [7:0] fe, fg;
  } vec_t;
  vec_t tv[18];

  function automatic vec_t mk(logic v, logic c, logic [7:0] cnt, logic lk, logic ep, logic es,
                              logic [15:0] ec, logic [7:0] ex, logic fv, logic [7:0] fe, logic [7:0] fg);
    vec_t r;
    r.v = v; r.c = c; r.cnt = cnt; r.lk = lk; r.ep = ep; r.es = es;
    r.ec = ec; r.ex = ex; r.fv = fv; r.fe = fe; r.fg = fg;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic step(input logic v, input logic c, input logic [7:0] cnt);
    @(negedge clk);
    reset = 1'b0; count_valid = v; clear = c; count_in = cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; count_valid = 1'b1; clear = 1'b1; count_in = 8'h55;
    @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_error", error, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_exp", exp_count, 0);
    chk("rst_fev", fev, 0);
    chk("rst_fexp", fexp, 0);
    chk("rst_fgot", fgot, 0);
    chk("rst_ec4", ec4, 0);
  endtask

  function automatic logic want_err(logic pulse, logic sticky);
`ifdef COUNT_CHECK_STICKY_ERR_EN
    return sticky;
`else
    return pulse;
`endif
  endfunction

  initial begin
    logic [7:0] e;
    reset = 1'b1; count_valid = 1'b0; clear = 1'b0; count_in = '0;
    for (int i = 0; i < 12; i++)
      tv[i] = mk(1, 0, 8'(i), i >= 4, 0, 0, 0, 8'(i + 1), 0, 0, 0);
    tv[12] = mk(1, 0, 99, 1, 1, 1, 1, 13, 1, 12, 99);
    tv[13] = mk(1, 0, 13, 1, 0, 1, 1, 14, 1, 12, 99);
    tv[14] = mk(1, 0, 14, 1, 0, 1, 1, 15, 1, 12, 99);
    tv[15] = mk(1, 1, 77, 1, 1, 1, 1, 16, 1, 15, 77);
    tv[16] = mk(1, 0, 16, 1, 0, 1, 1, 17, 1, 15, 77);
    tv[17] = mk(1, 1, 17, 1, 0, 0, 0, 18, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(tv[i].v, tv[i].c, tv[i].cnt);
      chk($sformatf("t%0d_locked", i), locked, tv[i].lk);
      chk($sformatf("t%0d_error", i), error, want_err(tv[i].ep, tv[i].es));
      chk($sformatf("t%0d_err_count", i), err_count, tv[i].ec);
      chk($sformatf("t%0d_exp", i), exp_count, tv[i].ex);
      chk($sformatf("t%0d_fev", i), fev, tv[i].fv);
      chk($sformatf("t%0d_fexp", i), fexp, tv[i].fe);
      chk($sformatf("t%0d_fgot", i), fgot, tv[i].fg);
    end

    // wrap-around 255 -> 0 while locked
    do_reset();
    for (int i = 245; i < 250; i++) step(1, 0, 8'(i));
    chk("wrap_lock", locked, 1);
    chk("wrap_lock_exp", exp_count, 250);
    for (int i = 250; i < 259; i++) begin
      step(1, 0, 8'(i));
      chk($sformatf("wrap_%0d_error", i), error, 0);
      chk($sformatf("wrap_%0d_locked", i), locked, 1);
    end
    chk("wrap_exp", exp_count, 3);
    chk("wrap_err_count", err_count, 0);

    // two consecutive misses drop lock, then reacquire
    step(1, 0, 3);
    step(1, 0, 4);
    step(1, 0, 50);
    chk("loss1_error", error, 1);
    chk("loss1_locked", locked, 1);
    chk("loss1_exp", exp_count, 6);
    step(1, 0, 51);
    chk("loss2_error", error, 1);
    chk("loss2_locked", locked, 0);
    chk("loss2_err_count", err_count, 2);
    chk("loss2_exp", exp_count, 52);
    chk("loss2_fexp", fexp, 5);
    chk("loss2_fgot", fgot, 50);
    for (int i = 52; i < 55; i++) step(1, 0, 8'(i));
    chk("reacq_locked_54", locked, 0);
    step(1, 0, 55);
    step(1, 0, 56);
    chk("reacq_locked_56", locked, 1);
    chk("reacq_err_count", err_count, 2);
    chk("reacq_exp", exp_count, 57);
    chk("reacq_error", error, want_err(0, 1));

    // count_valid gaps with a holding counter
    step(1, 0, 57);
    step(0, 0, 57);
    chk("gap1_exp", exp_count, 58);
    chk("gap1_error", error, want_err(0, 1));
    step(0, 0, 57);
    chk("gap2_exp", exp_count, 58);
    step(1, 0, 58);
    chk("gap_end_exp", exp_count, 59);
    chk("gap_end_err_count", err_count, 2);
    chk("gap_end_locked", locked, 1);

    // isolated glitches saturate the 4-bit counter
    e = 8'd59;
    for (int k = 0; k < 20; k++) begin
      step(1, 0, e + 8'd100);
      chk($sformatf("glitch%0d_error", k), error, 1);
      step(1, 0, e + 8'd1);
      e = e + 8'd2;
    end
    chk("sat_ec4", ec4, 15);
    chk("sat_err_count", err_count, 22);
    chk("sat_locked", locked, 1);
    chk("sat_exp", exp_count, 99);

    // reset mid-lock, then relock by the normal rule
    do_reset();
    step(1, 0, 7);
    chk("relock_seed_locked", locked, 0);
    chk("relock_seed_exp", exp_count, 8);
    chk("relock_seed_error", error, 0);
    for (int i = 8; i < 11; i++) step(1, 0, 8'(i));
    chk("relock_10_locked", locked, 0);
    step(1, 0, 11);
    chk("relock_11_locked", locked, 1);
    chk("relock_exp", exp_count, 12);
    chk("relock_err_count", err_count, 0);
    chk("relock_ec4", ec4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
